// File: rtl/enemy_target_sequencer_pkg.sv
// Purpose : shared types and constants for the enemy target sequencer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
//
// Contents: state enum, LFSR seed and tap mask, default targeting pattern.
package enemy_targeting_pkg;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Taps for x^8+x^6+x^5+x^4+1, as bit positions 7,5,4,3 of the shift register.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } seq_state_t;

  // Base 16-entry targeting sequence; other depths repeat or truncate it.
  localparam logic [1:0] DEFAULT_SEQ [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2
  };

  function automatic logic [1:0] default_entry(input int unsigned i);
    return DEFAULT_SEQ[i[3:0]];
  endfunction

endpackage

// File: rtl/enemy_target_sequencer_if.sv
// Purpose : request/result and pattern-load bundle between wave controller and sequencer.
// Latency : n/a (wiring only).
// Backpr. : requester must hold off while busy; results are single-cycle pulses.
//
// master = wave controller (drives req/mode/alive_mask/load_*), slave = sequencer.
interface enemy_target_sequencer_if #(
  parameter  int DEPTH       = 16,
  parameter  int IDX_W       = 3,
  parameter  int NUM_TARGETS = 6,
  localparam int PTR_W       = $clog2(DEPTH)
);
  logic                   req;
  logic                   mode;
  logic [NUM_TARGETS-1:0] alive_mask;
  logic                   load_en;
  logic [PTR_W-1:0]       load_addr;
  logic [IDX_W-1:0]       load_data;
  logic                   busy;
  logic                   tgt_valid;
  logic [IDX_W-1:0]       tgt_idx;
  logic                   tgt_none;

  modport master (
    output req, mode, alive_mask, load_en, load_addr, load_data,
    input  busy, tgt_valid, tgt_idx, tgt_none
  );

  modport slave (
    input  req, mode, alive_mask, load_en, load_addr, load_data,
    output busy, tgt_valid, tgt_idx, tgt_none
  );
endinterface

// File: rtl/enemy_target_sequencer_lfsr.sv
// Purpose : free-running 8-bit Fibonacci LFSR supplying random strides.
// Latency : new value every clock; q is a register output.
// Backpr. : none, never stalls.
//
// Ports: clk, rst_n (async active-low, loads LFSR_SEED), q = current state.
module target_lfsr
  import enemy_targeting_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  // Shift-and-XOR of a nonzero state can never reach zero, so no lock-up guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/enemy_target_sequencer.sv
// Purpose : hands out one alive target per request from a circular, loadable pattern.
// Latency : result k edges after acceptance (k = examined entries, 1..DEPTH).
// Backpr. : req ignored while busy=1; result is a one-cycle tgt_valid pulse.
//
// Ports: clk, rst_n; bus (slave) carries req/mode/alive_mask/load_* in and
//        busy/tgt_valid/tgt_idx/tgt_none out. All outputs are registered.
module enemy_target_sequencer
  import enemy_targeting_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int IDX_W       = 3,
  parameter  int NUM_TARGETS = 6,
  localparam int PTR_W       = $clog2(DEPTH)
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  enemy_target_sequencer_if.slave  bus
);

  localparam int               NSLOT    = 1 << IDX_W;
  localparam logic [PTR_W:0]   CNT_LAST = (PTR_W+1)'(DEPTH - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] pattern [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] stride;
  logic [PTR_W:0]   cnt;
  logic [7:0]       lfsr;

  logic             busy_q;
  logic             valid_q;
  logic             none_q;
  logic [IDX_W-1:0] idx_q;

  target_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Zero-extending the mask to every encodable index makes out-of-range
  // pattern values read as dead, so one lookup covers both hit conditions.
  logic [NSLOT-1:0] alive_ext;
  logic [IDX_W-1:0] entry;
  logic             hit;
  logic [PTR_W-1:0] new_stride;

  always_comb begin
    alive_ext  = NSLOT'(bus.alive_mask);
    entry      = pattern[ptr];
    hit        = alive_ext[entry];
    // Odd stride is coprime with a power-of-two depth: full coverage in DEPTH steps.
    new_stride = bus.mode ? (PTR_W'(lfsr) | PTR_W'(1)) : PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= PTR_W'(DEPTH - 1);
      stride  <= PTR_W'(1);
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      none_q  <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pattern[i] <= IDX_W'(default_entry(i));
      end
    end else begin
      valid_q <= 1'b0;
      none_q  <= 1'b0;

      // A write to the entry under examination lands after this cycle's lookup.
      if (bus.load_en) begin
        pattern[bus.load_addr] <= bus.load_data;
      end

      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            stride <= new_stride;
            ptr    <= ptr + new_stride;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (hit) begin
            // ptr parks on the hit so the next request starts one stride beyond it.
            valid_q <= 1'b1;
            idx_q   <= entry;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            valid_q <= 1'b1;
            none_q  <= 1'b1;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            ptr <= ptr + stride;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.tgt_valid = valid_q;
  assign bus.tgt_none  = none_q;
  assign bus.tgt_idx   = idx_q;

endmodule

// File: tb/tb_enemy_target_sequencer.sv
// Purpose : self-checking bench for enemy_target_sequencer against a queue/array model.
// Latency : n/a.
// Backpr. : n/a.
module tb_enemy_target_sequencer;

  localparam int DEPTH = 16;
  localparam int IDX_W = 3;
  localparam int NT    = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enemy_target_sequencer_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_TARGETS(NT)) bus ();

  enemy_target_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_TARGETS(NT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain pattern array and read pointer, stride 1.
  int ref_seq [16] = '{1, 1, 2, 2, 0, 0, 0, 0, 2, 1, 1, 2, 1, 2, 2, 2};
  int m_pat [DEPTH];
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pat[i] = ref_seq[i % 16];
    m_ptr = DEPTH - 1;
  endtask

  task automatic model_req(input logic [NT-1:0] alive, output int k,
                           output logic [IDX_W-1:0] idx, output logic none);
    m_ptr = (m_ptr + 1) % DEPTH;
    for (int kk = 1; kk <= DEPTH; kk++) begin
      if (m_pat[m_ptr] < NT && alive[m_pat[m_ptr]]) begin
        k = kk; idx = IDX_W'(m_pat[m_ptr]); none = 1'b0;
        return;
      end
      if (kk < DEPTH) m_ptr = (m_ptr + 1) % DEPTH;
    end
    k = DEPTH; idx = '0; none = 1'b1;
  endtask

  task automatic do_reset();
    bus.req = 0; bus.mode = 0; bus.alive_mask = '1;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_load(input int addr, input int data);
    bus.load_en = 1'b1; bus.load_addr = 4'(addr); bus.load_data = IDX_W'(data);
    @(posedge clk); #1;
    bus.load_en = 1'b0;
    m_pat[addr] = data;
  endtask

  // Observes one request/result transaction; comparisons are made by the caller.
  task automatic issue_req(input logic md, input logic poke, output int k,
                           output logic [IDX_W-1:0] idx, output logic none,
                           output int busy_cyc, output logic busy_at_valid);
    bus.mode = md; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    k = -1; idx = 'x; none = 1'bx; busy_cyc = 0; busy_at_valid = 1'bx;
    if (bus.busy === 1'b1) busy_cyc++;
    if (poke) bus.req = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      bus.req = 1'b0;
      if (bus.tgt_valid === 1'b1) begin
        k = e; idx = bus.tgt_idx; none = bus.tgt_none; busy_at_valid = bus.busy;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 0; bus.load_en = 0;
    #2;
    n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.tgt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.tgt_valid); end
    n_tests++; if (bus.tgt_none !== 1'b0)  begin n_fail++; $display("FAIL rst_none got %b want 0", bus.tgt_none); end
    n_tests++; if (bus.tgt_idx !== 3'd0)   begin n_fail++; $display("FAIL rst_idx got %0d want 0", bus.tgt_idx); end
    do_reset();
    n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL post_rst_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_sequential();
    int k, bc; logic [IDX_W-1:0] idx; logic none, bv;
    logic [IDX_W-1:0] exp_idx [3] = '{3'd1, 3'd1, 3'd2};
    do_reset();
    bus.alive_mask = 6'b111111;
    for (int r = 0; r < 3; r++) begin
      issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
      n_tests++; if (k !== 1) begin n_fail++; $display("FAIL seq_lat[%0d] got %0d want 1", r, k); end
      n_tests++; if (idx !== exp_idx[r]) begin n_fail++; $display("FAIL seq_idx[%0d] got %0d want %0d", r, idx, exp_idx[r]); end
      n_tests++; if (none !== 1'b0) begin n_fail++; $display("FAIL seq_none[%0d] got %b want 0", r, none); end
      @(posedge clk); #1;
      n_tests++; if (bus.tgt_valid !== 1'b0) begin n_fail++; $display("FAIL seq_pulse[%0d] got %b want 0", r, bus.tgt_valid); end
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_dead_skip();
    int k, bc; logic [IDX_W-1:0] idx; logic none, bv;
    do_reset();
    bus.alive_mask = 6'b111101;
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (k !== 3)      begin n_fail++; $display("FAIL dead_lat got %0d want 3", k); end
    n_tests++; if (idx !== 3'd2) begin n_fail++; $display("FAIL dead_idx got %0d want 2", idx); end
    n_tests++; if (bc !== 3)     begin n_fail++; $display("FAIL dead_busy_cycles got %0d want 3", bc); end
    n_tests++; if (bv !== 1'b0)  begin n_fail++; $display("FAIL dead_busy_at_valid got %b want 0", bv); end
  endtask

  task automatic test_no_target();
    int k, bc; logic [IDX_W-1:0] idx; logic none, bv;
    do_reset();
    bus.alive_mask = '0;
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (k !== DEPTH)  begin n_fail++; $display("FAIL none_lat got %0d want %0d", k, DEPTH); end
    n_tests++; if (none !== 1'b1) begin n_fail++; $display("FAIL none_flag got %b want 1", none); end
    n_tests++; if (idx !== 3'd0) begin n_fail++; $display("FAIL none_idx got %0d want 0", idx); end
    @(posedge clk); #1;
    n_tests++; if (bus.tgt_none !== 1'b0) begin n_fail++; $display("FAIL none_pulse got %b want 0", bus.tgt_none); end
    bus.alive_mask = '1;
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (idx !== 3'd1 || k !== 1) begin n_fail++; $display("FAIL none_wrap got idx %0d lat %0d want idx 1 lat 1", idx, k); end
  endtask

  task automatic test_load();
    int k, bc; logic [IDX_W-1:0] idx; logic none, bv;
    do_reset();
    bus.alive_mask = '1;
    do_load(0, 5);
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (idx !== 3'd5 || k !== 1) begin n_fail++; $display("FAIL load5 got idx %0d lat %0d want idx 5 lat 1", idx, k); end
    do_reset();
    do_load(0, 7);
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (idx !== 3'd1 || k !== 2) begin n_fail++; $display("FAIL load7 got idx %0d lat %0d want idx 1 lat 2", idx, k); end
  endtask

  task automatic test_lfsr_mode();
    int k, bc, extra; logic [IDX_W-1:0] idx; logic none, bv;
    do_reset();
    bus.alive_mask = 6'b000001;
    for (int r = 0; r < 8; r++) begin
      issue_req(1'b1, r == 0, k, idx, none, bc, bv);
      n_tests++; if (k < 1 || k > DEPTH) begin n_fail++; $display("FAIL lfsr_lat[%0d] got %0d want 1..%0d", r, k, DEPTH); end
      n_tests++; if (idx !== 3'd0 || none !== 1'b0) begin n_fail++; $display("FAIL lfsr_res[%0d] got idx %0d none %b want idx 0 none 0", r, idx, none); end
      if (r == 0) begin
        extra = 0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); #1;
          if (bus.tgt_valid === 1'b1) extra++;
        end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL busy_req_ignored got %0d extra pulses want 0", extra); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, bc; logic [IDX_W-1:0] idx; logic none, bv;
    do_reset();
    bus.alive_mask = '1;
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    // Re-request in the tgt_valid cycle itself.
    issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
    n_tests++; if (idx !== 3'd1 || k !== 1) begin n_fail++; $display("FAIL b2b got idx %0d lat %0d want idx 1 lat 1", idx, k); end
  endtask

  task automatic test_reset_midsearch();
    int k, bc, ek; logic [IDX_W-1:0] idx, eidx; logic none, bv, enone;
    do_reset();
    do_load(0, 3);
    bus.alive_mask = '0;
    bus.mode = 1'b0; bus.req = 1'b1;
    @(posedge clk); #1 bus.req = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.tgt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst got busy %b valid %b want 0 0", bus.busy, bus.tgt_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    bus.alive_mask = '1;
    for (int r = 0; r < 3; r++) begin
      model_req(bus.alive_mask, ek, eidx, enone);
      issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
      n_tests++; if (idx !== eidx || k !== ek) begin n_fail++; $display("FAIL midrst_pat[%0d] got idx %0d lat %0d want idx %0d lat %0d", r, idx, k, eidx, ek); end
    end
  endtask

  task automatic test_random();
    int k, bc, ek; logic [IDX_W-1:0] idx, eidx; logic none, bv, enone;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) do_load($urandom_range(0, DEPTH-1), $urandom_range(0, 7));
      bus.alive_mask = NT'($urandom);
      model_req(bus.alive_mask, ek, eidx, enone);
      issue_req(1'b0, 1'b0, k, idx, none, bc, bv);
      n_tests++;
      if (k !== ek || idx !== eidx || none !== enone || bc !== ek) begin
        n_fail++;
        $display("FAIL rand[%0d] got lat %0d idx %0d none %b busy %0d want lat %0d idx %0d none %b busy %0d",
                 r, k, idx, none, bc, ek, eidx, enone, ek);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_dead_skip();
    test_no_target();
    test_load();
    test_lfsr_mode();
    test_back_to_back();
    test_reset_midsearch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
